// File: rtl/cardinal_fetch_stage.sv
// -----------------------------------------------------------------------------
// cardinal_fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register for the 4-stage
//   Cardinal core (IF, ID, EXMEM, WB). Owns the PC and drives a synchronous
//   instruction memory with 1-cycle read latency. A one-entry hold buffer
//   parks a returning fetch while IF/ID is stalled, so that no instruction
//   is lost or duplicated across stalls and branch flushes.
//
//   Instruction bit numbering is MSB-first: bit 0 is the MSB of the word.
//   So the opcode [0:5] is instr[INSTR_WIDTH-1 -: 6].
//
// Ports:
//   i_clk, i_reset        core clock, synchronous active-high reset
//   i_pc_stall            hold PC, issue no new fetch
//   i_IF_ID_stall         hold IF/ID register contents
//   i_branch_taken        ID resolved a taken branch this cycle
//   i_branch_target       redirect address, valid with i_branch_taken
//   o_imem_addr           instruction memory address (= PC register)
//   o_imem_en             fetch request this cycle
//   i_imem_data           read data for the address issued the previous cycle
//   o_IF_ID_instr         instruction in ID (all-zero is NOP)
//   o_IF_ID_pc            PC of o_IF_ID_instr
//   o_IF_ID_valid         o_IF_ID_instr is a real instruction
//   o_IF_ID_instr_type    opcode field [0:5]
//   o_IF_ID_reg1          [6:10] for beq/bneq (100010/100011), else [11:15]
//   o_IF_ID_reg2          [16:20]
//
// Optional feature (macro CARDINAL_FETCH_PERF_EN):
//   o_perf_stall_cycles   cycles with pc_stall | IF_ID_stall
//   o_perf_flushes        cycles with branch_taken
//   o_perf_fetches        cycles with imem_en
//   All three clear on reset and saturate at all-ones.
// -----------------------------------------------------------------------------
module cardinal_fetch_stage #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  PC_STEP     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_pc_stall,
    input  logic                   i_IF_ID_stall,
    input  logic                   i_branch_taken,
    input  logic [PC_WIDTH-1:0]    i_branch_target,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    output logic                   o_imem_en,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    output logic [INSTR_WIDTH-1:0] o_IF_ID_instr,
    output logic [PC_WIDTH-1:0]    o_IF_ID_pc,
    output logic                   o_IF_ID_valid,
    output logic [5:0]             o_IF_ID_instr_type,
    output logic [4:0]             o_IF_ID_reg1,
`ifdef CARDINAL_FETCH_PERF_EN
    output logic [4:0]             o_IF_ID_reg2,
    output logic [31:0]            o_perf_stall_cycles,
    output logic [31:0]            o_perf_flushes,
    output logic [31:0]            o_perf_fetches
`else
    output logic [4:0]             o_IF_ID_reg2
`endif
);

    localparam int MSB = INSTR_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // nothing in flight
        S_RUN  = 2'd1,   // one fetch in flight, data returns this cycle
        S_HELD = 2'd2    // returned data parked in the hold buffer
    } state_t;

    state_t                 r_state,        w_state_nxt;
    logic [PC_WIDTH-1:0]    r_pc,           w_pc_nxt;
    logic [PC_WIDTH-1:0]    r_tag,          w_tag_nxt;      // PC of in-flight fetch
    logic [INSTR_WIDTH-1:0] r_hold_instr,   w_hold_instr_nxt;
    logic [PC_WIDTH-1:0]    r_hold_pc,      w_hold_pc_nxt;
    logic [INSTR_WIDTH-1:0] r_ifid_instr,   w_ifid_instr_nxt;
    logic [PC_WIDTH-1:0]    r_ifid_pc,      w_ifid_pc_nxt;
    logic                   r_ifid_valid,   w_ifid_valid_nxt;
    logic                   w_imem_en;

    assign w_imem_en = !i_reset && !i_pc_stall && !i_IF_ID_stall && !i_branch_taken;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_tag        <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_tag        <= w_tag_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    // Next-state logic: branch > IF/ID stall > normal advance
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_tag_nxt        = r_tag;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_valid_nxt = r_ifid_valid;

        if (i_branch_taken) begin
            // Redirect: drop whatever is in flight or parked, bubble into ID.
            w_pc_nxt         = i_branch_target;
            w_ifid_instr_nxt = '0;
            w_ifid_pc_nxt    = '0;
            w_ifid_valid_nxt = 1'b0;
            w_hold_instr_nxt = '0;
            w_hold_pc_nxt    = '0;
            w_state_nxt      = S_IDLE;
        end else if (i_IF_ID_stall) begin
            // IF/ID and PC hold. A returning fetch must be caught now or lost.
            // No fetch issues while stalled, so the single-entry buffer suffices.
            if (r_state == S_RUN) begin
                w_hold_instr_nxt = i_imem_data;
                w_hold_pc_nxt    = r_tag;
                w_state_nxt      = S_HELD;
            end
        end else begin
            case (r_state)
                S_HELD: begin
                    w_ifid_instr_nxt = r_hold_instr;
                    w_ifid_pc_nxt    = r_hold_pc;
                    w_ifid_valid_nxt = 1'b1;
                end
                S_RUN: begin
                    w_ifid_instr_nxt = i_imem_data;
                    w_ifid_pc_nxt    = r_tag;
                    w_ifid_valid_nxt = 1'b1;
                end
                default: begin
                    w_ifid_instr_nxt = '0;
                    w_ifid_pc_nxt    = '0;
                    w_ifid_valid_nxt = 1'b0;
                end
            endcase

            if (w_imem_en) begin
                w_pc_nxt    = r_pc + PC_WIDTH'(PC_STEP);   // wraps modulo 2^PC_WIDTH
                w_tag_nxt   = r_pc;
                w_state_nxt = S_RUN;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // Outputs and hazard-field decode
    logic [5:0] w_opcode;
    logic       w_is_branch;

    assign w_opcode    = r_ifid_instr[MSB -: 6];
    assign w_is_branch = (w_opcode == 6'b100010) || (w_opcode == 6'b100011);

    assign o_imem_addr        = r_pc;
    assign o_imem_en          = w_imem_en;
    assign o_IF_ID_instr      = r_ifid_instr;
    assign o_IF_ID_pc         = r_ifid_pc;
    assign o_IF_ID_valid      = r_ifid_valid;
    assign o_IF_ID_instr_type = w_opcode;
    assign o_IF_ID_reg1       = w_is_branch ? r_ifid_instr[MSB-6 -: 5]
                                            : r_ifid_instr[MSB-11 -: 5];
    assign o_IF_ID_reg2       = r_ifid_instr[MSB-16 -: 5];

`ifdef CARDINAL_FETCH_PERF_EN
    logic [31:0] r_perf_stall, r_perf_flush, r_perf_fetch;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_fetch <= '0;
        end else begin
            if ((i_pc_stall || i_IF_ID_stall) && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (i_branch_taken && (r_perf_flush != '1))
                r_perf_flush <= r_perf_flush + 32'd1;
            if (w_imem_en && (r_perf_fetch != '1))
                r_perf_fetch <= r_perf_fetch + 32'd1;
        end
    end

    assign o_perf_stall_cycles = r_perf_stall;
    assign o_perf_flushes      = r_perf_flush;
    assign o_perf_fetches      = r_perf_fetch;
`endif

endmodule

// File: tb/tb_cardinal_fetch_stage.sv
// Directed bench for cardinal_fetch_stage. Stimulus pushes the expected
// instruction stream into a scoreboard queue; a negedge monitor pops one entry
// each time ID consumes a valid IF/ID instruction. A few cycle-exact checks
// (addresses, bubbles, decode) are made inline by the stimulus process.
module tb_cardinal_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, pc_stall, IF_ID_stall, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_data;
    logic        imem_en;
    logic [31:0] IF_ID_instr, IF_ID_pc;
    logic        IF_ID_valid;
    logic [5:0]  IF_ID_instr_type;
    logic [4:0]  IF_ID_reg1, IF_ID_reg2;

    always #5 clk = ~clk;

    cardinal_fetch_stage dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_pc_stall         (pc_stall),
        .i_IF_ID_stall      (IF_ID_stall),
        .i_branch_taken     (branch_taken),
        .i_branch_target    (branch_target),
        .o_imem_addr        (imem_addr),
        .o_imem_en          (imem_en),
        .i_imem_data        (imem_data),
        .o_IF_ID_instr      (IF_ID_instr),
        .o_IF_ID_pc         (IF_ID_pc),
        .o_IF_ID_valid      (IF_ID_valid),
        .o_IF_ID_instr_type (IF_ID_instr_type),
        .o_IF_ID_reg1       (IF_ID_reg1),
        .o_IF_ID_reg2       (IF_ID_reg2)
    );

    // Instruction memory: word = addr>>2 unless overridden
    logic [31:0] ovr [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return a >> 2;
    endfunction

    initial imem_data = '0;
    always @(posedge clk) if (imem_en) imem_data <= mem_word(imem_addr);

    // Scoreboard
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          dec;
        logic [5:0]  typ;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc; e.instr = instr; e.dec = 1'b0; e.typ = '0; e.r1 = '0; e.r2 = '0;
        sbq.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [5:0] typ, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        e.pc = pc; e.instr = instr; e.dec = 1'b1; e.typ = typ; e.r1 = r1; e.r2 = r2;
        sbq.push_back(e);
    endtask

    // ID consumes IF/ID at the next edge when valid and not held (a branch
    // resolving in ID also retires the instruction sitting there).
    always @(negedge clk) begin
        if (!reset && IF_ID_valid && (!IF_ID_stall || branch_taken)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected pc actual=%h expected=none", IF_ID_pc);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_pc", IF_ID_pc, mon_e.pc);
                chk("sb_instr", IF_ID_instr, mon_e.instr);
                if (mon_e.dec) begin
                    chk("sb_type", 32'(IF_ID_instr_type), 32'(mon_e.typ));
                    chk("sb_reg1", 32'(IF_ID_reg1), 32'(mon_e.r1));
                    chk("sb_reg2", 32'(IF_ID_reg2), 32'(mon_e.r2));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // beq: 100010 00010 10011 00000 ... ; R-type: 101010 00001 00010 00011 ...
        // bneq: 100011 00010 10011 00000 ...
        ovr[32'h104] = 32'h8853_0000;
        ovr[32'h108] = 32'hA822_1800;
        ovr[32'h10C] = 32'h8C53_0000;

        reset = 1'b1; pc_stall = 1'b0; IF_ID_stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        repeat (2) tick();
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_en",    32'(imem_en), 32'h0);
        chk("rst_valid", 32'(IF_ID_valid), 32'h0);
        chk("rst_instr", IF_ID_instr, 32'h0);
        chk("rst_pc",    IF_ID_pc, 32'h0);

        // Sequential run, then a 3-cycle stall with PC=8 in flight
        push(32'h0, 32'h0); push(32'h4, 32'h1); push(32'h8, 32'h2); push(32'hC, 32'h3);
        reset = 1'b0;
        tick(); chk("run_addr1", imem_addr, 32'h4); chk("run_valid1", 32'(IF_ID_valid), 32'h0);
        tick(); chk("run_valid2", 32'(IF_ID_valid), 32'h1); chk("run_pc2", IF_ID_pc, 32'h0);
        tick(); chk("run_pc3", IF_ID_pc, 32'h4); chk("run_addr3", imem_addr, 32'hC);
        pc_stall = 1'b1; IF_ID_stall = 1'b1; #1;
        chk("stall_en", 32'(imem_en), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'hC);
            chk("stall_pc", IF_ID_pc, 32'h4);
        end
        pc_stall = 1'b0; IF_ID_stall = 1'b0;
        tick(); chk("rel_pc_hold", IF_ID_pc, 32'h8); chk("rel_instr_hold", IF_ID_instr, 32'h2);
        tick(); chk("rel_pc_next", IF_ID_pc, 32'hC);

        // Branch while stalled with PC=16 in flight; 16 must never reach ID
        push(32'h100, 32'h40);
        push_d(32'h104, 32'h8853_0000, 6'b100010, 5'd2, 5'd0);
        push_d(32'h108, 32'hA822_1800, 6'b101010, 5'd2, 5'd3);
        pc_stall = 1'b1; IF_ID_stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100; #1;
        chk("br_en", 32'(imem_en), 32'h0);
        tick(); chk("br_addr", imem_addr, 32'h100); chk("br_valid", 32'(IF_ID_valid), 32'h0);
        pc_stall = 1'b0; IF_ID_stall = 1'b0; branch_taken = 1'b0;
        tick(); chk("br_bubble", 32'(IF_ID_valid), 32'h0); chk("br_addr2", imem_addr, 32'h104);
        tick(); chk("br_pc", IF_ID_pc, 32'h100);
        tick(); tick(); tick();
        chk("bneq_pc",   IF_ID_pc, 32'h10C);
        chk("bneq_type", 32'(IF_ID_instr_type), 32'h23);
        chk("bneq_reg1", 32'(IF_ID_reg1), 32'h2);
        chk("bneq_reg2", 32'(IF_ID_reg2), 32'h0);

        // IF/ID stall alone parks the returning fetch; reset while HELD
        IF_ID_stall = 1'b1;
        tick(); chk("held_addr", imem_addr, 32'h114); chk("held_pc", IF_ID_pc, 32'h10C);
        reset = 1'b1;
        tick(); chk("hrst_valid", 32'(IF_ID_valid), 32'h0); chk("hrst_addr", imem_addr, 32'h0);
        chk("hrst_instr", IF_ID_instr, 32'h0);
        push(32'h0, 32'h0); push(32'h4, 32'h1); push(32'h8, 32'h2);
        reset = 1'b0; IF_ID_stall = 1'b0;
        tick(); chk("hrst_nostale", 32'(IF_ID_valid), 32'h0); chk("hrst_addr1", imem_addr, 32'h4);
        tick(); chk("hrst_pc0", IF_ID_pc, 32'h0);
        tick(); tick();

        // PC wrap from 0xFFFFFFFC to 0
        push(32'hFFFF_FFFC, 32'h3FFF_FFFF); push(32'h0, 32'h0);
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        tick(); chk("wrap_addr1", imem_addr, 32'h0);
        tick(); chk("wrap_pc", IF_ID_pc, 32'hFFFF_FFFC);
        tick(); chk("wrap_pc_next", IF_ID_pc, 32'h0);
        tick();
        IF_ID_stall = 1'b1;
        repeat (3) tick();
        chk("sb_drain", 32'(sbq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
